// File: rtl/dense_seq_pkg.sv
// Shared types and helpers for the dense layer sequencer.
// Holds the sequencer state encoding and the address-width function.
package dense_seq_pkg;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eACCUM = 2'd1,
    eBIAS  = 2'd2,
    eDONE  = 2'd3
  } seq_state_e;

  function automatic int addr_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dense_layer_sequencer_index_counter.sv
// Frame index counter for the dense layer sequencer.
// Clear beats enable; the count saturates at MAX+1 instead of wrapping.
module index_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 10
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             last_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MAX + 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: clear first, then a guarded increment
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != TOP)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST);

endmodule

// File: rtl/dense_layer_sequencer.sv
// Sequences one dense layer frame through a shared MAC array.
// Streams INPUT_SIZE words, adds a bias step, then holds the result.
module dense_layer_sequencer
  import dense_seq_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int INPUT_SIZE = 10,
  parameter int ADDR_WIDTH = addr_width(INPUT_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WORD_SIZE-1:0]  data_i,
  output logic [WORD_SIZE-1:0]  mac_data_o,
  output logic                  mac_en_o,
  output logic                  mac_clear_o,
  output logic                  bias_sel_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  // Counter must reach INPUT_SIZE+1, one past the bias row.
  localparam int CNT_W = $clog2(INPUT_SIZE + 2);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(INPUT_SIZE);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;

  assign ready_o = !reset_i &&
                   (state_q == eIDLE || state_q == eACCUM);
  assign accept  = valid_i && ready_o;

  assign mac_en_o    = !reset_i &&
                       (accept || state_q == eBIAS);
  assign bias_sel_o  = !reset_i && (state_q == eBIAS);
  assign valid_o     = !reset_i && (state_q == eDONE);
  assign mac_clear_o = reset_i ||
                       (state_q == eDONE && ready_i);
  assign mac_data_o  = data_i;

  assign addr_o = reset_i ? '0 :
                  (cnt > SAT) ? ADDR_WIDTH'(SAT) :
                  ADDR_WIDTH'(cnt);

  index_counter #(
    .WIDTH (CNT_W),
    .MAX   (INPUT_SIZE)
  ) u_idx (
    .clk_i   (clk_i),
    .clear_i (mac_clear_o),
    .en_i    (mac_en_o),
    .count_o (cnt),
    .last_o  (last)
  );

  // state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      eIDLE, eACCUM: begin
        if (accept) begin
          state_d = last ? eBIAS : eACCUM;
        end
      end
      eBIAS: state_d = eDONE;
      eDONE: begin
        if (ready_i) begin
          state_d = eIDLE;
        end
      end
      default: state_d = eIDLE;
    endcase
  end

  a_addr_range: assert property (
    @(posedge clk_i) disable iff (reset_i)
    addr_o <= ADDR_WIDTH'(INPUT_SIZE));

  a_en_vs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i)
    !(mac_en_o && valid_o));

  a_bias_en: assert property (
    @(posedge clk_i) disable iff (reset_i)
    bias_sel_o |-> mac_en_o);

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Scoreboard bench for dense_layer_sequencer.
// Two instances: INPUT_SIZE=4 (A) and INPUT_SIZE=1 (B).
module tb_dense_layer_sequencer;

  typedef struct {
    bit          sel;
    bit          rst;
    bit          v;
    bit          r;
    logic [15:0] d;
    bit          e_rdy;
    bit          e_en;
    bit          e_clr;
    bit          e_bias;
    int          e_addr;
    bit          e_val;
    string       nm;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, v_a = 1'b0, r_a = 1'b0;
  logic [15:0] d_a = '0;
  logic        rdy_a, en_a, clr_a, bias_a, val_a;
  logic [15:0] md_a;
  logic [2:0]  addr_a;

  logic        rst_b = 1'b1, v_b = 1'b0, r_b = 1'b0;
  logic [15:0] d_b = '0;
  logic        rdy_b, en_b, clr_b, bias_b, val_b;
  logic [15:0] md_b;
  logic [0:0]  addr_b;

  dense_layer_sequencer #(
    .WORD_SIZE(16), .INPUT_SIZE(4)
  ) dut_a (
    .clk_i(clk), .reset_i(rst_a), .valid_i(v_a),
    .ready_o(rdy_a), .data_i(d_a), .mac_data_o(md_a),
    .mac_en_o(en_a), .mac_clear_o(clr_a),
    .bias_sel_o(bias_a), .addr_o(addr_a),
    .valid_o(val_a), .ready_i(r_a)
  );

  dense_layer_sequencer #(
    .WORD_SIZE(16), .INPUT_SIZE(1)
  ) dut_b (
    .clk_i(clk), .reset_i(rst_b), .valid_i(v_b),
    .ready_o(rdy_b), .data_i(d_b), .mac_data_o(md_b),
    .mac_en_o(en_b), .mac_clear_o(clr_b),
    .bias_sel_o(bias_b), .addr_o(addr_b),
    .valid_o(val_b), .ready_i(r_b)
  );

  vec_t q[$];
  int checks = 0;
  int errors = 0;
  int en_cnt_a = 0;

  task automatic chk(input string nm, input string f,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d",
               nm, f, act, exp);
    end
  endtask

  // monitor: pop the expected vector and compare each cycle
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          if (en_a) en_cnt_a++;
          chk(e.nm, "ready_o", int'(rdy_a), int'(e.e_rdy));
          chk(e.nm, "mac_en_o", int'(en_a), int'(e.e_en));
          chk(e.nm, "mac_clear_o", int'(clr_a), int'(e.e_clr));
          chk(e.nm, "bias_sel_o", int'(bias_a), int'(e.e_bias));
          chk(e.nm, "addr_o", int'(addr_a), e.e_addr);
          chk(e.nm, "valid_o", int'(val_a), int'(e.e_val));
          chk(e.nm, "mac_data_o", int'(md_a), int'(e.d));
        end else begin
          chk(e.nm, "ready_o", int'(rdy_b), int'(e.e_rdy));
          chk(e.nm, "mac_en_o", int'(en_b), int'(e.e_en));
          chk(e.nm, "mac_clear_o", int'(clr_b), int'(e.e_clr));
          chk(e.nm, "bias_sel_o", int'(bias_b), int'(e.e_bias));
          chk(e.nm, "addr_o", int'(addr_b), e.e_addr);
          chk(e.nm, "valid_o", int'(val_b), int'(e.e_val));
          chk(e.nm, "mac_data_o", int'(md_b), int'(e.d));
        end
      end
    end
  end

  task automatic cyc(input bit sel, input bit rst,
                     input bit v, input bit r,
                     input logic [15:0] d,
                     input bit erdy, input bit een,
                     input bit eclr, input bit ebias,
                     input int eaddr, input bit eval,
                     input string nm);
    vec_t e;
    @(posedge clk);
    #1;
    if (!sel) begin
      rst_a = rst; v_a = v; r_a = r; d_a = d;
      rst_b = 1'b1; v_b = 1'b0; r_b = 1'b0; d_b = '0;
    end else begin
      rst_b = rst; v_b = v; r_b = r; d_b = d;
      rst_a = 1'b1; v_a = 1'b0; r_a = 1'b0; d_a = '0;
    end
    e.sel = sel; e.rst = rst; e.v = v; e.r = r; e.d = d;
    e.e_rdy = erdy; e.e_en = een; e.e_clr = eclr;
    e.e_bias = ebias; e.e_addr = eaddr; e.e_val = eval;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic rst(input bit s);
    cyc(s, 1, 1, 0, 16'h0, 0, 0, 1, 0, 0, 0, "reset");
  endtask
  task automatic word(input bit s, input logic [15:0] d,
                      input int a, input bit r);
    cyc(s, 0, 1, r, d, 1, 1, 0, 0, a, 0, "word");
  endtask
  task automatic gap(input bit s, input int a);
    cyc(s, 0, 0, 1, 16'h0055, 1, 0, 0, 0, a, 0, "gap");
  endtask
  task automatic bias(input bit s, input int a, input bit v);
    cyc(s, 0, v, 1, 16'h00B1, 0, 1, 0, 1, a, 0, "bias");
  endtask
  task automatic done(input bit s, input int a,
                      input bit r, input bit v);
    cyc(s, 0, v, r, 16'hBEEF, 0, 0, r, 0, a, 1, "done");
  endtask
  task automatic idle(input bit s);
    cyc(s, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic frame4(input logic [15:0] base);
    for (int i = 0; i < 4; i++) word(0, base + 16'(i), i, 1);
    bias(0, 4, 1);
    done(0, 4, 1, 1);
  endtask

  // driver: directed vectors with hand-computed expectations
  initial begin
    int s0;
    rst(0); rst(0);
    // full frame, data 1..4
    frame4(16'd1);
    idle(0);
    // two-cycle gap after word 2
    word(0, 16'd5, 0, 1); word(0, 16'd6, 1, 1);
    gap(0, 2); gap(0, 2);
    word(0, 16'd7, 2, 1); word(0, 16'd8, 3, 1);
    bias(0, 4, 0); done(0, 4, 1, 0); idle(0);
    // downstream stalls five cycles in DONE
    for (int i = 0; i < 4; i++) word(0, 16'h10 + 16'(i), i, 0);
    bias(0, 4, 1);
    for (int i = 0; i < 5; i++) done(0, 4, 0, 1);
    done(0, 4, 1, 1);
    word(0, 16'h20, 0, 1);
    word(0, 16'h21, 1, 1);
    // reset after two accepts
    rst(0);
    idle(0);
    frame4(16'd1);
    idle(0);
    // back-to-back frames, 6-cycle period
    @(negedge clk); #1;
    s0 = en_cnt_a;
    frame4(16'h30);
    frame4(16'h40);
    @(negedge clk); #1;
    checks++;
    if (en_cnt_a - s0 != 10) begin
      errors++;
      $display("FAIL b2b_en_count: got %0d expected 10",
               en_cnt_a - s0);
    end
    idle(0);
    // INPUT_SIZE=1 instance
    rst(1);
    word(1, 16'd7, 0, 1);
    bias(1, 1, 0);
    done(1, 1, 1, 0);
    idle(1);
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
